// File: rtl/dac_run_ctrl.sv
// -----------------------------------------------------------------------------
// dac_run_ctrl
//
// Run sequencer for one DAC channel. The PS programs the timing of the
// sequence over its GPIO bus: one shared serial data line (sdata) and one
// serial clock per configuration register. Configuration shifts are only
// accepted while this channel's bit in the one-hot channel-select register is
// set. A PS trigger then walks the channel through PRE (delay), RUN (FIFO
// playback) and POST (delay) phases, finishing with a one-cycle DONE pulse.
//
// Optional feature, macro DAC_RUN_MASK_EN:
//   defined   - a 1-bit mask_en register is shifted on mask_enable_clk and,
//               when set, run_mask flags the first and last RUN cycle.
//   undefined - no mask register, mask_enable_clk is ignored, run_mask = 0.
//
// Parameters:
//   CHANNEL_INDEX  select-register bit that addresses this instance (0..15)
//   GPIO_W         GPIO bus width
//   CNT_W          width of the pre-delay / run / post-delay registers
//   SEL_W          channel-select register width
//
// Ports:
//   clk       in   fabric clock
//   rst       in   asynchronous active-high reset
//   gpio_in   in   PS GPIO bus:  0 sdata, 2 channel_sel_clk, 3 cycle_count_clk,
//                  5 pl_rst, 6 trigger_line, 9 pre_delay_cycle_clk,
//                  10 post_delay_cycle_clk, 12 mask_enable_clk
//   run_en    out  FIFO read/play enable, high only in RUN
//   busy      out  high in PRE, RUN and POST
//   done      out  one-cycle pulse when a sequence completes
//   run_mask  out  waveform edge mask (optional feature)
//   sel_hit   out  channel-select bit CHANNEL_INDEX is set
// -----------------------------------------------------------------------------
module dac_run_ctrl #(
  parameter int CHANNEL_INDEX = 0,
  parameter int GPIO_W        = 16,
  parameter int CNT_W         = 32,
  parameter int SEL_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              run_en,
  output logic              busy,
  output logic              done,
  output logic              run_mask,
  output logic              sel_hit
);

  // GPIO bit positions
  localparam int B_SDATA    = 0;
  localparam int B_SEL_CLK  = 2;
  localparam int B_RUN_CLK  = 3;
  localparam int B_PL_RST   = 5;
  localparam int B_TRIG     = 6;
  localparam int B_PRE_CLK  = 9;
  localparam int B_POST_CLK = 10;
  localparam int B_MASK_CLK = 12;

  // Positions of the used lines inside the local synchroniser vectors
  localparam int I_SDATA = 0;
  localparam int I_SEL   = 1;
  localparam int I_RUN   = 2;
  localparam int I_PLRST = 3;
  localparam int I_TRIG  = 4;
  localparam int I_PRE   = 5;
  localparam int I_POST  = 6;
  localparam int I_MASK  = 7;

  localparam logic [GPIO_W-1:0] G_ONE = {{(GPIO_W-1){1'b0}}, 1'b1};
  localparam logic [GPIO_W-1:0] USED_BASE = (G_ONE << B_SDATA)   | (G_ONE << B_SEL_CLK) |
                                            (G_ONE << B_RUN_CLK) | (G_ONE << B_PL_RST)  |
                                            (G_ONE << B_TRIG)    | (G_ONE << B_PRE_CLK) |
                                            (G_ONE << B_POST_CLK);
`ifdef DAC_RUN_MASK_EN
  localparam int NSYNC = 8;
  localparam logic [GPIO_W-1:0] USED_MASK = USED_BASE | (G_ONE << B_MASK_CLK);
`else
  localparam int NSYNC = 7;
  localparam logic [GPIO_W-1:0] USED_MASK = USED_BASE;
`endif

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_RUN  = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // First phase with a nonzero count, in sequence order; DONE if none.
  // Phases already completed are passed in as zero.
  function automatic state_t first_phase(input logic [CNT_W-1:0] pre,
                                         input logic [CNT_W-1:0] run,
                                         input logic [CNT_W-1:0] post);
    if (pre != CNT_ZERO)       return S_PRE;
    else if (run != CNT_ZERO)  return S_RUN;
    else if (post != CNT_ZERO) return S_POST;
    else                       return S_DONE;
  endfunction

  // Counter value on entry to a phase: the counter runs down to 0, so a
  // phase of N cycles starts at N-1.
  function automatic logic [CNT_W-1:0] phase_load(input state_t           st,
                                                  input logic [CNT_W-1:0] pre,
                                                  input logic [CNT_W-1:0] run,
                                                  input logic [CNT_W-1:0] post);
    case (st)
      S_PRE:   return pre - CNT_ONE;
      S_RUN:   return run - CNT_ONE;
      S_POST:  return post - CNT_ONE;
      default: return CNT_ZERO;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisation and edge detection
  // ---------------------------------------------------------------------------
  logic [NSYNC-1:0] gpio_used;
  logic [NSYNC-1:0] sync1_q, sync2_q;
  logic [NSYNC-1:1] sync3_q;
  logic [NSYNC-1:1] stb;
  logic             unused_gpio;

  always_comb begin
    gpio_used          = '0;
    gpio_used[I_SDATA] = gpio_in[B_SDATA];
    gpio_used[I_SEL]   = gpio_in[B_SEL_CLK];
    gpio_used[I_RUN]   = gpio_in[B_RUN_CLK];
    gpio_used[I_PLRST] = gpio_in[B_PL_RST];
    gpio_used[I_TRIG]  = gpio_in[B_TRIG];
    gpio_used[I_PRE]   = gpio_in[B_PRE_CLK];
    gpio_used[I_POST]  = gpio_in[B_POST_CLK];
`ifdef DAC_RUN_MASK_EN
    gpio_used[I_MASK]  = gpio_in[B_MASK_CLK];
`endif
  end

  assign unused_gpio = ^(gpio_in & ~USED_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= gpio_used;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q[NSYNC-1:1];
    end
  end

  // sdata is a level sampled at the same synchroniser depth as the strobes,
  // so a data bit set up with its serial clock is seen by that clock's strobe.
  logic sdata_s;
  logic trig_stb;
  logic soft_rst;

  assign stb      = sync2_q[NSYNC-1:1] & ~sync3_q;
  assign sdata_s  = sync2_q[I_SDATA];
  assign trig_stb = stb[I_TRIG];
  // A held pl_rst keeps the sequencer parked in IDLE, not just the edge.
  assign soft_rst = stb[I_PLRST] | sync2_q[I_PLRST];

  // ---------------------------------------------------------------------------
  // Select and configuration shift registers (shadow copies)
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] pre_cfg_q, run_cfg_q, post_cfg_q;
`ifdef DAC_RUN_MASK_EN
  logic             mask_cfg_q;
`endif

  assign sel_hit = sel_q[CHANNEL_INDEX];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= '0;
      pre_cfg_q  <= '0;
      run_cfg_q  <= '0;
      post_cfg_q <= '0;
`ifdef DAC_RUN_MASK_EN
      mask_cfg_q <= 1'b0;
`endif
    end else begin
      // The select register shifts in every instance on the shared bus.
      if (stb[I_SEL])             sel_q      <= {sel_q[SEL_W-2:0], sdata_s};
      if (sel_hit && stb[I_PRE])  pre_cfg_q  <= {pre_cfg_q[CNT_W-2:0], sdata_s};
      if (sel_hit && stb[I_RUN])  run_cfg_q  <= {run_cfg_q[CNT_W-2:0], sdata_s};
      if (sel_hit && stb[I_POST]) post_cfg_q <= {post_cfg_q[CNT_W-2:0], sdata_s};
`ifdef DAC_RUN_MASK_EN
      if (sel_hit && stb[I_MASK]) mask_cfg_q <= sdata_s;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_run_q, act_post_q;
  logic             capture;
`ifdef DAC_RUN_MASK_EN
  logic             act_mask_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (soft_rst) begin
      state_d = S_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Shadows are read before any same-cycle shift lands.
          if (trig_stb && sel_hit) begin
            capture = 1'b1;
            state_d = first_phase(pre_cfg_q, run_cfg_q, post_cfg_q);
            cnt_d   = phase_load(state_d, pre_cfg_q, run_cfg_q, post_cfg_q);
          end
        end
        S_PRE: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = first_phase(CNT_ZERO, act_run_q, act_post_q);
            cnt_d   = phase_load(state_d, CNT_ZERO, act_run_q, act_post_q);
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_RUN: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = first_phase(CNT_ZERO, CNT_ZERO, act_post_q);
            cnt_d   = phase_load(state_d, CNT_ZERO, CNT_ZERO, act_post_q);
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_POST: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = S_DONE;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    run_en   = (state_q == S_RUN);
    busy     = (state_q == S_PRE) || (state_q == S_RUN) || (state_q == S_POST);
    done     = (state_q == S_DONE);
    run_mask = 1'b0;
`ifdef DAC_RUN_MASK_EN
    // First RUN cycle has cnt = run-1, last has cnt = 0; both coincide when
    // run = 1, giving a single mask cycle.
    if ((state_q == S_RUN) && act_mask_q &&
        ((cnt_q == CNT_ZERO) || (cnt_q == (act_run_q - CNT_ONE))))
      run_mask = 1'b1;
`endif
  end

  // Phase counter and active copies taken at trigger time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      act_run_q  <= '0;
      act_post_q <= '0;
`ifdef DAC_RUN_MASK_EN
      act_mask_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      if (capture) begin
        act_run_q  <= run_cfg_q;
        act_post_q <= post_cfg_q;
`ifdef DAC_RUN_MASK_EN
        act_mask_q <= mask_cfg_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_dac_run_ctrl.sv
`timescale 1ns/1ps
module tb_dac_run_ctrl;

  localparam int GPIO_W = 16;
  localparam int CNT_W  = 32;
  localparam int SEL_W  = 16;
`ifdef DAC_RUN_MASK_EN
  localparam int M1 = 1;
  localparam int M2 = 2;
`else
  localparam int M1 = 0;
  localparam int M2 = 0;
`endif

  // GPIO lines
  localparam int G_SDATA = 0, G_SEL = 2, G_RUN = 3, G_PLRST = 5, G_TRIG = 6;
  localparam int G_PRE = 9, G_POST = 10, G_MASK = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [GPIO_W-1:0] gpio;
  logic              run_en, busy, done, run_mask, sel_hit;

  dac_run_ctrl #(
    .CHANNEL_INDEX(0),
    .GPIO_W       (GPIO_W),
    .CNT_W        (CNT_W),
    .SEL_W        (SEL_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .gpio_in (gpio),
    .run_en  (run_en),
    .busy    (busy),
    .done    (done),
    .run_mask(run_mask),
    .sel_hit (sel_hit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Expected shape of one sequence, offsets relative to the trigger edge E0.
  typedef struct {
    int e0;
    int busy_off;   // first busy cycle, -1 if never
    int run_off;    // first run_en cycle, -1 if never
    int run_cnt;
    int done_off;   // -1 if the sequence is aborted
    int end_off;    // first cycle with all outputs low again
    int mask_cnt;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: collects one activity burst and scores it against the queue.
  initial begin : monitor
    bit   active;
    int   fb, fr, rc, dc, mc, da;
    logic any;
    exp_t e;
    active = 1'b0;
    fb = -1; fr = -1; rc = 0; dc = 0; mc = 0; da = -1;
    forever begin
      @(negedge clk);
      any = busy | run_en | done | run_mask;
      if (any === 1'b1) begin
        if (!active) begin
          active = 1'b1;
          fb = -1; fr = -1; rc = 0; dc = 0; mc = 0; da = -1;
          check("expectation queued at activity start", int'(sb.size() > 0), 1);
        end
        if (busy && fb < 0) fb = cyc;
        if (run_en) begin
          if (fr < 0) fr = cyc;
          rc++;
        end
        if (done) begin
          dc++;
          da = cyc;
        end
        if (run_mask) mc++;
        check("run_mask only with run_en", int'(run_mask & ~run_en), 0);
      end else if (active) begin
        active = 1'b0;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("busy rise offset", (fb < 0) ? -1 : fb - e.e0, e.busy_off);
          check("run_en start offset", (fr < 0) ? -1 : fr - e.e0, e.run_off);
          check("run_en cycles", rc, e.run_cnt);
          check("done offset", (da < 0) ? -1 : da - e.e0, e.done_off);
          check("done pulse cycles", dc, (e.done_off < 0) ? 0 : 1);
          check("idle offset", cyc - e.e0, e.end_off);
          check("run_mask cycles", mc, e.mask_cnt);
        end
      end
    end
  end

  // Shift `width` bits MSB first on serial clock line `clk_bit`. If trig_at
  // is >= 0, a trigger pulse is issued together with that bit.
  task automatic shift_bits(input int clk_bit, input logic [31:0] val,
                            input int width, input int trig_at);
    for (int i = width - 1; i >= 0; i--) begin
      @(negedge clk);
      gpio[G_SDATA] = val[i];
      gpio[clk_bit] = 1'b1;
      if ((width - 1 - i) == trig_at) gpio[G_TRIG] = 1'b1;
      @(negedge clk);
      gpio[clk_bit] = 1'b0;
      gpio[G_TRIG]  = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic load_cfg(input int pre, input int run, input int post);
    shift_bits(G_PRE, pre, CNT_W, -1);
    shift_bits(G_RUN, run, CNT_W, -1);
    shift_bits(G_POST, post, CNT_W, -1);
  endtask

  task automatic trigger(input bit expect_seq, input int b, input int r,
                         input int rc, input int d, input int en, input int m,
                         output int e0);
    exp_t x;
    @(negedge clk);
    gpio[G_TRIG] = 1'b1;
    e0 = cyc + 1;
    if (expect_seq) begin
      x.e0 = e0; x.busy_off = b; x.run_off = r; x.run_cnt = rc;
      x.done_off = d; x.end_off = en; x.mask_cnt = m;
      sb.push_back(x);
    end
    repeat (2) @(negedge clk);
    gpio[G_TRIG] = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d sequences still expected after %0d cycles, required 0",
               sb.size(), budget);
      sb.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin : stim
    int e0;
    rst  = 1'b1;
    gpio = '0;
    repeat (3) @(negedge clk);
    check("reset run_en", int'(run_en), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset run_mask", int'(run_mask), 0);
    check("reset sel_hit", int'(sel_hit), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic sequence pre=5 run=10 post=3
    shift_bits(G_SEL, 32'h0001, SEL_W, -1);
    check("sel_hit after sel=0001", int'(sel_hit), 1);
    shift_bits(G_MASK, 32'h1, 1, -1);
    load_cfg(5, 10, 3);
    trigger(1'b1, 2, 7, 10, 20, 21, M2, e0);
    wait_drain(300);

    // Channel not selected: trigger and config writes ignored
    shift_bits(G_SEL, 32'h0002, SEL_W, -1);
    check("sel_hit after sel=0002", int'(sel_hit), 0);
    load_cfg(0, 1, 0);
    trigger(1'b0, 0, 0, 0, 0, 0, 0, e0);
    repeat (40) @(negedge clk);
    shift_bits(G_SEL, 32'h0001, SEL_W, -1);
    trigger(1'b1, 2, 7, 10, 20, 21, M2, e0);
    wait_drain(300);

    // Retrigger and run_cfg rewrite while busy
    trigger(1'b1, 2, 7, 10, 20, 21, M2, e0);
    shift_bits(G_RUN, 32'd2, CNT_W, 3);
    wait_drain(300);
    trigger(1'b1, 2, 7, 2, 12, 13, M2, e0);
    wait_drain(300);

    // Soft reset mid-RUN, then retrigger with retained config
    shift_bits(G_RUN, 32'd10, CNT_W, -1);
    trigger(1'b1, 2, 7, 5, -1, 12, M1, e0);
    wait_cyc(e0 + 9);
    gpio[G_PLRST] = 1'b1;
    repeat (2) @(negedge clk);
    gpio[G_PLRST] = 1'b0;
    repeat (6) @(negedge clk);
    wait_drain(300);
    trigger(1'b1, 2, 7, 10, 20, 21, M2, e0);
    wait_drain(300);

    // All phases zero
    load_cfg(0, 0, 0);
    trigger(1'b1, -1, -1, 0, 2, 3, 0, e0);
    wait_drain(300);

    // RUN only, 4 cycles
    shift_bits(G_RUN, 32'd4, CNT_W, -1);
    trigger(1'b1, 2, 2, 4, 6, 7, M2, e0);
    wait_drain(300);

    // RUN only, single cycle
    shift_bits(G_RUN, 32'd1, CNT_W, -1);
    trigger(1'b1, 2, 2, 1, 3, 4, M1, e0);
    wait_drain(300);

    // Hard reset mid-RUN: nothing resumes, select register cleared
    load_cfg(5, 10, 3);
    trigger(1'b1, 2, 7, 3, -1, 10, M1, e0);
    wait_cyc(e0 + 9);
    #2;
    rst = 1'b1;
    #1;
    check("async reset run_en", int'(run_en), 0);
    check("async reset busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("sel_hit after hard reset", int'(sel_hit), 0);
    wait_drain(50);
    trigger(1'b0, 0, 0, 0, 0, 0, 0, e0);
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
